rsfq_serial_add_ctrl: RTL
=========================

// Module: rsfq_serial_add_ctrl
// PURPOSE
//  Bit-serial controller wrapped around the pipelined 1-bit full-adder stage (autoadd).
//  - Upstream: accepts a WIDTH-bit operand pair and carry-in over a valid/ready handshake.
//  - Issues bits LSB-first on the adder's A/B/Carry_in.
//  - Captures Sum/Carry_out after the adder's fixed pipeline latency.
//  - Downstream: returns the WIDTH-bit sum and carry-out over a valid/ready handshake.
// PARAMETERS
//  WIDTH    8  operand/sum width in bits (>=2)
//  ADD_LAT  3  adder clocks from A/B/Carry_in input to Sum/Carry_out valid (>=1)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      controller can accept operands (high only in IDLE)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  op_ci      in   1      carry-in to bit 0
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  op_a + op_b + op_ci, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  add_a      out  1      to adder A
//  add_b      out  1      to adder B
//  add_ci     out  1      to adder Carry_in
//  add_sum    in   1      from adder Sum
//  add_co     in   1      from adder Carry_out
// BEHAVIOUR
//  Reset (async assert, clean on deassert):
//   - State IDLE.
//   - in_ready=1, out_valid=0, sum=0, cout=0.
//   - add_a/add_b/add_ci=0; bit index=0; wait counter=0.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: latch op_a, op_b; carry register := op_ci; bit index i := 0; go to ISSUE.
//  ISSUE (exactly 1 cycle):
//   - Registered add_a=a[i], add_b=b[i], add_ci=carry, high for this cycle only.
//   - Go to WAIT with counter := ADD_LAT.
//  WAIT:
//   - add_* driven 0 (adder idle; no overlapping bits, because the carry dependency forbids it).
//   - Counter decrements each cycle.
//   - In the cycle the counter reaches 1 (ADD_LAT cycles after the ISSUE cycle): sum[i] := add_sum, carry := add_co.
//   - Then, if i==WIDTH-1, go to DONE; otherwise i := i+1 and go to ISSUE.
//  DONE:
//   - out_valid=1; cout=carry.
//   - sum/cout held stable while out_valid & !out_ready.
//   - On out_ready: out_valid drops next cycle; go to IDLE.
//  Latency:
//   - Accept at cycle 0; bit i issued at cycle 1+i*(ADD_LAT+1).
//   - out_valid rises at cycle 1+WIDTH*(ADD_LAT+1); with defaults, cycle 33.
//  Boundary conditions:
//   - in_valid is ignored outside IDLE (in_ready=0); no back-to-back acceptance while DONE.
//   - out_ready asserted before out_valid has no effect.
//   - Overflow wraps modulo 2^WIDTH; the carry is reported only on cout.
//   - Reset mid-operation aborts immediately, discards the partial sum, and forces add_*=0.
//   - add_sum/add_co are sampled only at the capture cycle; pulses at any other time are ignored.
// CONFIGURATION
//  Macro RSFQ_SADD_OVF_EN:
//   - Defined: adds output port ovf (out, 1).
//   - ovf = signed overflow = carry into MSB XOR carry out of MSB.
//   - Carry into MSB is captured as the carry register before bit WIDTH-1 is issued.
//   - ovf is valid with out_valid, holds with sum, and resets to 0.
//   - Undefined: the ovf port and its logic are absent; everything else is identical.
// TESTING
//  1 Defaults; a=8'h3C, b=8'h0F, ci=0 -> sum=8'h4B, cout=0, out_valid at cycle 33.
//  2 a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, cout=1; [OVF_EN] ovf=0.
//  3 a=8'h7F, b=8'h01, ci=0 -> sum=8'h80, cout=0; [OVF_EN] ovf=1.
//  4 a=8'hFF, b=8'hFF, ci=1 -> sum=8'hFF, cout=1;
//    hold out_ready=0 for 10 cycles -> out_valid and sum stable, in_ready=0.
//  5 Assert rst at cycle 12 of a transfer -> same cycle: out_valid=0, in_ready=1, add_*=0;
//    next op a=8'h01, b=8'h02 -> sum=8'h03.
//  6 ADD_LAT=1, WIDTH=4; a=4'h9, b=4'h8, ci=1 -> sum=4'h2, cout=1, out_valid at cycle 9;
//    check add_a is high only in ISSUE cycles 1, 3, 5, 7 when the corresponding a bit is 1.

Source files
------------

// File: rtl/rsfq_serial_add_ctrl.sv
// Bit-serial add sequencer feeding a pipelined 1-bit full adder, LSB first, one bit in flight.
// Define RSFQ_SADD_OVF_EN to add the signed-overflow output port ovf.
module rsfq_serial_add_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RSFQ_SADD_OVF_EN
  output logic             ovf,
`endif
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_sum,
  input  logic             add_co
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_add_a;
  logic             r_add_b;
  logic             r_add_ci;
`ifdef RSFQ_SADD_OVF_EN
  logic             r_ovf;
`endif

  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_last;
  logic [IW-1:0]    w_idx_inc;
  logic             w_add_a_nxt;
  logic             w_add_b_nxt;
  logic             w_add_ci_nxt;

  // Next state plus the bit to present to the adder in the following ISSUE cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_last       = (r_idx == IW'(WIDTH - 1));
    w_idx_inc    = r_idx + IW'(1);
    w_add_a_nxt  = 1'b0;
    w_add_b_nxt  = 1'b0;
    w_add_ci_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_nxt  = S_ISSUE;
          w_add_a_nxt  = op_a[0];
          w_add_b_nxt  = op_b[0];
          w_add_ci_nxt = op_ci;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            // The carry just returned by the adder feeds the next bit directly
            w_state_nxt  = S_ISSUE;
            w_add_a_nxt  = r_a[w_idx_inc];
            w_add_b_nxt  = r_b[w_idx_inc];
            w_add_ci_nxt = add_co;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake/adder outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add_a     <= 1'b0;
      r_add_b     <= 1'b0;
      r_add_ci    <= 1'b0;
`ifdef RSFQ_SADD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_add_a     <= w_add_a_nxt;
      r_add_b     <= w_add_b_nxt;
      r_add_ci    <= w_add_ci_nxt;
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_carry <= op_ci;
        r_idx   <= {IW{1'b0}};
        r_sum   <= {WIDTH{1'b0}};
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= CW'(ADD_LAT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_sum[r_idx] <= add_sum;
        r_carry      <= add_co;
        if (w_last) begin
          r_cout <= add_co;
`ifdef RSFQ_SADD_OVF_EN
          // r_carry still holds the carry into the MSB here
          r_ovf  <= r_carry ^ add_co;
`endif
        end else begin
          r_idx <= w_idx_inc;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_ci    = r_add_ci;
`ifdef RSFQ_SADD_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
